fetch_buffer: RTL and testbench

- Instruction fetch front-end with a prefetch queue. Sits between the instruction ROM and the F/D pipeline register.
- Generates fetch addresses and absorbs the ROM's fixed 1-cycle read latency.
- Holds fetched instructions with their PC and PC+4 until decode accepts them.
- Honours decode stalls and execute-stage redirects (taken branch / jump / jalr).

---
 rtl/fetch_buffer.sv | 119 +++++++++++
 tb/tb_fetch_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch front-end: issues sequential ROM reads, absorbs the ROM's
// one-cycle latency and queues {instr, pc} entries for decode.
module fetch_buffer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  StallD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] ImemAddr,
  output logic                  ImemReq,
  input  logic [DATA_WIDTH-1:0] ImemRdata,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  ValidF
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [OW-1:0] occ_t;

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  kill_q, kill_d;
  cnt_t                  count_q, count_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] last_pc_q, last_pc4_q;

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];

  logic pop, push, issue;
  occ_t occ;

  // Head outputs come straight from the registered queue; PC/PC+4 hold when empty.
  always_comb begin
    ValidF   = (count_q != '0);
    InstrF   = ValidF ? instr_mem[rd_ptr_q] : NOP_INSTR;
    PCF      = ValidF ? pc_mem[rd_ptr_q] : last_pc_q;
    PCPlus4F = ValidF ? pc_mem[rd_ptr_q] + DATA_WIDTH'(4) : last_pc4_q;
    ImemAddr = fetch_pc_q;
    ImemReq  = issue;
  end

  // NOTE: every signal gets a default at the top of always_comb so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    pop   = ValidF & ~StallD & ~PCSrcE;
    push  = inflight_q & ~kill_q & ~PCSrcE;
    // Occupancy once this cycle's response lands; a new issue lands one cycle later.
    occ   = occ_t'(count_q) + occ_t'(inflight_q) - occ_t'(pop);
    issue = rst & trigger & ~PCSrcE & (occ < occ_t'(DEPTH));

    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
    rd_ptr_d   = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;

    if (issue) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);

    if (PCSrcE) begin
      fetch_pc_d = PCTargetE;
      kill_d     = inflight_q;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      last_pc_q  <= '0;
      last_pc4_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      last_pc_q  <= PCF;
      last_pc4_q <= PCPlus4F;
    end
  end

  // NOTE: queue storage has no reset; ValidF gates every read, so stale contents
  // are never observed and the arrays can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= ImemRdata;
      pc_mem[wr_ptr_q]    <= fetch_pc_q - DATA_WIDTH'(4);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && count_q == cnt_t'(DEPTH)));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: sequential fetch, stall fill, redirect,
// trigger drain, async reset and address wrap. ROM[addr] = addr + 0x100.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        StallD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ImemAddr;
  logic        ImemReq;
  logic [31:0] ImemRdata = '0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;

  int n_total = 0;
  int n_bad   = 0;

  fetch_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .StallD    (StallD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .ImemAddr  (ImemAddr),
    .ImemReq   (ImemReq),
    .ImemRdata (ImemRdata),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .ValidF    (ValidF)
  );

  always #5 clk = ~clk;

  // One-cycle-latency ROM model.
  always @(posedge clk) ImemRdata <= ImemAddr + 32'h100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, 32'(ValidF), 32'd1);
    check({tag, ".pc"}, PCF, pc);
    check({tag, ".instr"}, InstrF, pc + 32'h100);
    check({tag, ".pc4"}, PCPlus4F, pc + 32'd4);
  endtask

  task automatic empty(input string tag, input logic [31:0] held_pc);
    check({tag, ".valid"}, 32'(ValidF), 32'd0);
    check({tag, ".instr"}, InstrF, 32'h0000_0013);
    check({tag, ".pc"}, PCF, held_pc);
  endtask

  initial begin
    rst = 1'b0; trigger = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;

    // Reset state, then cycle 0 issues address 0.
    cyc();
    check("rst.req", 32'(ImemReq), 32'd0);
    check("rst.addr", ImemAddr, 32'h0);
    check("rst.pc4", PCPlus4F, 32'h0);
    empty("rst", 32'h0);
    rst = 1'b1; #1;
    check("c0.req", 32'(ImemReq), 32'd1);
    check("c0.addr", ImemAddr, 32'h0);

    // Cycle 1: still empty; from cycle 2 one instruction per cycle.
    cyc();
    check("c1.valid", 32'(ValidF), 32'd0);
    check("c1.addr", ImemAddr, 32'h4);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      head($sformatf("seq%0d", k), 32'((k - 2) * 4));
      check($sformatf("seq%0d.addr", k), ImemAddr, 32'(k * 4));
    end

    // Stall for cycles 4..9: queue fills, requests stop, head stays at 8.
    StallD = 1'b1; #1;
    check("st4.req", 32'(ImemReq), 32'd1);
    check("st4.addr", ImemAddr, 32'h10);
    cyc();
    check("st5.req", 32'(ImemReq), 32'd1);
    check("st5.addr", ImemAddr, 32'h14);
    for (int k = 6; k <= 9; k++) begin
      cyc();
      check($sformatf("st%0d.req", k), 32'(ImemReq), 32'd0);
      head($sformatf("st%0d", k), 32'h8);
    end

    // Release: 8, C, 10, 14 without gaps.
    cyc();
    StallD = 1'b0; #1;
    head("rel10", 32'h8);
    check("rel10.req", 32'(ImemReq), 32'd1);
    check("rel10.addr", ImemAddr, 32'h18);
    cyc(); head("rel11", 32'hC);
    cyc(); head("rel12", 32'h10);
    cyc(); head("rel13", 32'h14);

    // Redirect with count=3 and one request in flight.
    PCSrcE = 1'b1; PCTargetE = 32'h40; #1;
    check("rd13.req", 32'(ImemReq), 32'd0);
    cyc();
    PCSrcE = 1'b0; #1;
    empty("rd14", 32'h14);
    check("rd14.req", 32'(ImemReq), 32'd1);
    check("rd14.addr", ImemAddr, 32'h40);
    cyc();
    check("rd15.valid", 32'(ValidF), 32'd0);
    cyc();
    head("rd16", 32'h40);

    // Hold the head and stop fetching: exactly two entries drain.
    StallD = 1'b1; trigger = 1'b0; #1;
    check("tg16.req", 32'(ImemReq), 32'd0);
    cyc();
    StallD = 1'b0; #1;
    head("tg17", 32'h40);
    check("tg17.req", 32'(ImemReq), 32'd0);
    cyc(); head("tg18", 32'h44);
    cyc();
    empty("tg19", 32'h44);
    check("tg19.pc4", PCPlus4F, 32'h48);
    check("tg19.req", 32'(ImemReq), 32'd0);
    cyc();
    check("tg20.req", 32'(ImemReq), 32'd0);
    trigger = 1'b1; #1;
    check("tg20.req_on", 32'(ImemReq), 32'd1);
    check("tg20.addr", ImemAddr, 32'h48);
    cyc(); check("tg21.valid", 32'(ValidF), 32'd0);
    cyc(); head("tg22", 32'h48);
    cyc(); head("tg23", 32'h4C);

    // Async reset between clock edges.
    #2 rst = 1'b0; #1;
    empty("ar", 32'h0);
    check("ar.addr", ImemAddr, 32'h0);
    check("ar.req", 32'(ImemReq), 32'd0);
    cyc();
    rst = 1'b1; #1;
    check("ar24.addr", ImemAddr, 32'h0);
    check("ar24.req", 32'(ImemReq), 32'd1);
    cyc();
    check("ar25.valid", 32'(ValidF), 32'd0);
    check("ar25.addr", ImemAddr, 32'h4);
    cyc(); head("ar26", 32'h0);

    // Wrap: redirect to the top of the address space.
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    cyc();
    PCSrcE = 1'b0; #1;
    check("wr27.addr", ImemAddr, 32'hFFFF_FFFC);
    cyc();
    check("wr28.addr", ImemAddr, 32'h0);
    check("wr28.req", 32'(ImemReq), 32'd1);
    cyc();
    check("wr29.valid", 32'(ValidF), 32'd1);
    check("wr29.pc", PCF, 32'hFFFF_FFFC);
    check("wr29.instr", InstrF, 32'h0000_00FC);
    check("wr29.pc4", PCPlus4F, 32'h0);
    cyc(); head("wr30", 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
